mask_assembler: RTL

MASK_ASSEMBLER -- requirements
Module: mask_assembler

---
 rtl/mask_assembler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mask_assembler.sv
// rtl/mask_assembler.sv - collects index beats into a one-hot OR mask per frame
//
// Purpose: accepts a stream of bit indices, ORs their one-hot decodes into an
// accumulator, and presents the assembled mask, beat count and duplicate flag
// once the frame's last beat has been accepted. The result is held until the
// consumer takes it.
//
// Optional feature macro: MASK_ASSEMBLER_DUP_DETECT_EN (duplicate-index detection)
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   synchronous active-low reset
//   flush      in   discard the partially collected frame
//   in_valid   in   index beat valid
//   in_ready   out  index beat accepted when in_valid & in_ready
//   in_idx     in   [n-1:0] bit position to set
//   in_last    in   final beat of the frame
//   out_valid  out  assembled mask available
//   out_ready  in   consumer takes the mask
//   out_mask   out  [2**n-1:0] OR of one-hot decodes of the frame's indices
//   out_count  out  [n:0] accepted beats in frame, saturating at all-ones
//   out_dup    out  frame repeated an index (0 when detection is not built)

module mask_assembler #(
  parameter int n = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [n-1:0]      in_idx,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2**n-1:0]   out_mask,
  output logic [n:0]        out_count,
  output logic              out_dup
);

  localparam int w = 2**n;
  localparam logic [n:0] cnt_max = '1;

  typedef enum logic {
    st_collect = 1'b0,
    st_hold    = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [w-1:0] acc_q;
  logic [n:0]   cnt_q;
  logic [w-1:0] mask_q;
  logic [n:0]   count_q;

  logic         accept;
  logic [w-1:0] idx_onehot;
  logic [n:0]   cnt_inc;

  assign accept     = in_valid & in_ready;
  assign idx_onehot = {{(w-1){1'b0}}, 1'b1} << in_idx;
  assign cnt_inc    = (cnt_q == cnt_max) ? cnt_q : cnt_q + {{n{1'b0}}, 1'b1};

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= st_collect;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      st_collect: if (accept && in_last) state_d = st_hold;
      st_hold:    if (out_ready)         state_d = st_collect;
      default:                           state_d = st_collect;
    endcase
  end

  // Outputs decoded from state. in_ready is gated by reset_n so no beat
  // appears accepted while the block is being reset.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      st_collect: in_ready  = reset_n & ~flush;
      st_hold:    out_valid = 1'b1;
      default:    ;
    endcase
  end

  // Accumulator, beat count and held result. The held registers are cleared
  // on the consumer handshake so the outputs read 0 whenever out_valid is 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        st_collect: begin
          if (flush) begin
            acc_q <= '0;
            cnt_q <= '0;
          end else if (accept) begin
            if (in_last) begin
              mask_q  <= acc_q | idx_onehot;
              count_q <= cnt_inc;
            end else begin
              acc_q <= acc_q | idx_onehot;
              cnt_q <= cnt_inc;
            end
          end
        end
        st_hold: begin
          if (out_ready) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            count_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_mask  = mask_q;
  assign out_count = count_q;

`ifdef MASK_ASSEMBLER_DUP_DETECT_EN
  logic dup_q;
  logic dup_out_q;
  logic dup_hit;

  // A beat is a duplicate when its bit is already present from earlier beats.
  assign dup_hit = acc_q[in_idx];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dup_q     <= 1'b0;
      dup_out_q <= 1'b0;
    end else begin
      case (state_q)
        st_collect: begin
          if (flush) begin
            dup_q <= 1'b0;
          end else if (accept) begin
            if (in_last) begin
              dup_out_q <= dup_q | dup_hit;
            end else begin
              dup_q <= dup_q | dup_hit;
            end
          end
        end
        st_hold: begin
          if (out_ready) begin
            dup_q     <= 1'b0;
            dup_out_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_dup = dup_out_q;
`else
  assign out_dup = 1'b0;
`endif

endmodule
